sync_fifo_flags: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's basic FIFO.
- Adds programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a defined simultaneous read/write rule.
- Optional first-word-fall-through read mode.
- Used as the standard single-clock buffer between producer and consumer stages.

---
 rtl/sync_fifo_flags.sv | 109 ++++++++++
 tb/tb_sync_fifo_flags.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  WR,
  input  logic                  RD,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] FULL_CNT = PW'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = PW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_CNT   = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    full         = (count_q == FULL_CNT);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_CNT);
    almost_empty = (count_q <= AE_CNT);
    count        = count_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    wr_acc       = WR & ~full;
    rd_acc       = RD & ~empty;
  end

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clr_err must survive the clear.
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    if (WR & full)  overflow_d  = 1'b1;
    if (RD & empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_W-1:0]] <= dataIn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown while non-empty; zero otherwise so reset leaves dataOut at 0.
  always_comb begin
    dataOut = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  end
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = rd_acc ? mem_q[rd_ptr_q[ADDR_W-1:0]] : dout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  always_comb begin
    dataOut = dout_q;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (default parameters).
// Read latency adapts to SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataIn;
  logic       WR, RD, clr_err;
  logic [7:0] dataOut;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int total = 0;
  int bad   = 0;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .WR(WR), .RD(RD), .dataOut(dataOut),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(output logic [7:0] w);
`ifdef SYNC_FIFO_FWFT_EN
    w  = dataOut;
    RD = 1'b1;
    tick();
    RD = 1'b0;
`else
    RD = 1'b1;
    tick();
    RD = 1'b0;
    w  = dataOut;
`endif
  endtask

  task automatic do_write(input logic [7:0] d);
    WR = 1'b1; dataIn = d;
    tick();
    WR = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; WR = 1'b0; RD = 1'b0; clr_err = 1'b0; dataIn = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000) begin
      bad++; $display("FAIL reset_flags got=%b want=110000",
                      {empty, almost_empty, full, almost_full, overflow, underflow});
    end
    total++;
    if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++;
    if (dataOut !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", dataOut); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] w;
    for (int i = 0; i < 16; i++) begin
      do_write(8'(i));
      total++;
      if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d want=%0d", count, i + 1); end
      total++;
      if ({almost_empty, almost_full, full} !== {(i + 1) <= 4, (i + 1) >= 12, (i + 1) == 16}) begin
        bad++; $display("FAIL fill_flags n=%0d got=%b want=%b", i + 1, {almost_empty, almost_full, full},
                        {(i + 1) <= 4, (i + 1) >= 12, (i + 1) == 16});
      end
    end
    do_write(8'hAA);
    total++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      bad++; $display("FAIL overflow_write got ovf=%b cnt=%0d want ovf=1 cnt=16", overflow, count);
    end
    for (int i = 0; i < 16; i++) begin
      do_read(w);
      total++;
      if (w !== 8'(i)) begin bad++; $display("FAIL drain_data got=%h want=%h", w, 8'(i)); end
      total++;
      if (count !== 5'(15 - i)) begin bad++; $display("FAIL drain_count got=%0d want=%0d", count, 15 - i); end
    end
    total++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      bad++; $display("FAIL drain_end got empty=%b unf=%b want empty=1 unf=0", empty, underflow);
    end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL clr_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_simul_empty();
    logic [7:0] w;
    WR = 1'b1; RD = 1'b1; dataIn = 8'h5A;
    tick();
    WR = 1'b0; RD = 1'b0;
    total++;
    if (underflow !== 1'b1 || count !== 5'd1 || empty !== 1'b0) begin
      bad++; $display("FAIL simul_empty got unf=%b cnt=%0d empty=%b want unf=1 cnt=1 empty=0",
                      underflow, count, empty);
    end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (dataOut !== 8'h0F) begin bad++; $display("FAIL simul_empty_hold got=%h want=0f", dataOut); end
`endif
    do_read(w);
    total++;
    if (w !== 8'h5A || count !== 5'd0) begin
      bad++; $display("FAIL simul_empty_read got=%h cnt=%0d want=5a cnt=0", w, count);
    end
  endtask

  task automatic test_simul_full();
    logic [7:0] w;
    for (int i = 0; i < 16; i++) do_write(8'(8'h10 + i));
    WR = 1'b1; RD = 1'b1; dataIn = 8'h77;
    tick();
    WR = 1'b0; RD = 1'b0;
    total++;
    if (overflow !== 1'b1 || count !== 5'd15 || full !== 1'b0) begin
      bad++; $display("FAIL simul_full got ovf=%b cnt=%0d full=%b want ovf=1 cnt=15 full=0",
                      overflow, count, full);
    end
`ifndef SYNC_FIFO_FWFT_EN
    total++;
    if (dataOut !== 8'h10) begin bad++; $display("FAIL simul_full_read got=%h want=10", dataOut); end
`endif
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    total++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL clr_err got ovf=%b unf=%b want 0 0", overflow, underflow);
    end
    for (int i = 1; i < 16; i++) begin
      do_read(w);
      total++;
      if (w !== 8'(8'h10 + i)) begin bad++; $display("FAIL full_drain got=%h want=%h", w, 8'(8'h10 + i)); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL full_drain_empty got=%b want=1", empty); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    for (int i = 0; i < 8; i++) do_write(8'(8'h80 + i));
    for (int k = 0; k < 40; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      w = dataOut;
`endif
      WR = 1'b1; RD = 1'b1; dataIn = 8'(8'h88 + k);
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      w = dataOut;
`endif
      total++;
      if (w !== 8'(8'h80 + k) || count !== 5'd8) begin
        bad++; $display("FAIL stream k=%0d got=%h cnt=%0d want=%h cnt=8", k, w, count, 8'(8'h80 + k));
      end
    end
    WR = 1'b0; RD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_read(w);
      total++;
      if (w !== 8'(8'hA8 + i)) begin bad++; $display("FAIL stream_drain got=%h want=%h", w, 8'(8'hA8 + i)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    for (int i = 0; i < 10; i++) do_write(8'(8'hC0 + i));
    total++;
    if (count !== 5'd10) begin bad++; $display("FAIL pre_reset_count got=%0d want=10", count); end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000 ||
        count !== 5'd0 || dataOut !== 8'h00) begin
      bad++; $display("FAIL async_reset got flags=%b cnt=%0d dout=%h want 110000 0 00",
                      {empty, almost_empty, full, almost_full, overflow, underflow}, count, dataOut);
    end
    rst = 1'b0;
    tick();
    do_write(8'h3C);
`ifdef SYNC_FIFO_FWFT_EN
    total++;
    if (dataOut !== 8'h3C || empty !== 1'b0) begin
      bad++; $display("FAIL fwft_visible got=%h empty=%b want=3c empty=0", dataOut, empty);
    end
`endif
    do_read(w);
    total++;
    if (w !== 8'h3C || count !== 5'd0) begin
      bad++; $display("FAIL post_reset_read got=%h cnt=%0d want=3c cnt=0", w, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simul_empty();
    test_simul_full();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
